// File: rtl/note_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : note_seq_pkg
//  Description : Shared types and constants for the note step sequencer:
//                write-FSM state encoding, note word field positions,
//                one-hot lane enables and the rest word used at reset.
//  Optional    : NOTE_SEQ_OSC_TRACK_EN (consumed by note_sequencer)
//  Revision    : 1.0  initial release
// ============================================================================
package note_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_LO     = 3'd1,
        ST_WR_HI     = 3'd2,
        ST_WR_OSC_LO = 3'd3,
        ST_WR_OSC_HI = 3'd4
    } seq_state_e;

    // Note word layout
    localparam int REST_BIT = 15;
    localparam int END_BIT  = 14;
    localparam int RSVD_MSB = 13;
    localparam int RSVD_LSB = 12;
    localparam int OCT_MSB  = 11;
    localparam int OCT_LSB  = 9;
    localparam int MANT_MSB = 8;
    localparam int MANT_LSB = 0;

    localparam logic [15:0] REST_WORD = 16'h8000;

    // One-hot lane enables of the synth config port
    localparam logic [7:0] LANE_NONE = 8'h00;
    localparam logic [7:0] LANE0_EN  = 8'h01;
    localparam logic [7:0] LANE1_EN  = 8'h02;
    localparam logic [7:0] LANE2_EN  = 8'h04;
    localparam logic [7:0] LANE3_EN  = 8'h08;

    // Low config byte: low eight mantissa bits
    function automatic logic [7:0] lane_lo_byte(input logic [15:0] word);
        return word[MANT_LSB +: 8];
    endfunction

    // High config byte: mantissa MSB plus octave, zero-extended
    function automatic logic [7:0] lane_hi_byte(input logic [15:0] word);
        return {4'b0000, word[OCT_MSB:OCT_LSB], word[MANT_MSB]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tempo_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tempo_divider
//  Description : Step-rate counter. While run is high it fires trigger on
//                the first cycle and then once every max(tempo,1) cycles.
//                While run is low the counter is parked at zero so the next
//                run assertion triggers immediately.
//  Ports       : clk, rst_n   clock, async active-low reset
//                run          level enable
//                tempo        cycles per step (0 behaves as 1)
//                trigger      combinational one-cycle step strobe
//  Revision    : 1.0  initial release
// ============================================================================
module tempo_divider #(
    parameter int TEMPO_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [TEMPO_BITS-1:0] tempo,
    output logic                  trigger
);

    logic [TEMPO_BITS-1:0] cnt_q;
    logic [TEMPO_BITS-1:0] cnt_d;
    logic [TEMPO_BITS-1:0] reload;

    always_comb begin
        // tempo of 0 reloads 0, giving the same one-cycle period as tempo 1
        reload  = (tempo == '0) ? '0 : tempo - TEMPO_BITS'(1);
        trigger = run && (cnt_q == '0);
        cnt_d   = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (trigger) begin
            cnt_d = reload;
        end else begin
            cnt_d = cnt_q - TEMPO_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : note_sequencer
//  Description : Step sequencer feeding the synth byte-wide config port.
//                Holds STEPS programmable note words, plays one per tempo
//                period and serialises each note into lane byte writes.
//  Optional    : NOTE_SEQ_OSC_TRACK_EN - when defined each note also writes
//                lanes 2 and 3 (oscillator filter tracking), 4 writes total.
//  Ports       : clk, rst_n            clock, async active-low reset
//                run, tempo            step enable, cycles per step
//                prog_we/addr/data     pattern write port
//                cfg_out, cfg_en       config byte and one-hot lane enable
//                step_idx              next step to be played
//                step_pulse            tempo trigger strobe
//                busy                  write sequence in progress
//                overrun               sticky dropped-trigger flag
//  Revision    : 1.0  initial release
// ============================================================================
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int STEPS      = 8,
    parameter int TEMPO_BITS = 16,
    parameter int IDX_BITS   = $clog2(STEPS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [TEMPO_BITS-1:0] tempo,
    input  logic                  prog_we,
    input  logic [IDX_BITS-1:0]   prog_addr,
    input  logic [15:0]           prog_data,
    output logic [7:0]            cfg_out,
    output logic [7:0]            cfg_en,
    output logic [IDX_BITS-1:0]   step_idx,
    output logic                  step_pulse,
    output logic                  busy,
    output logic                  overrun
);

    logic                trigger;
    seq_state_e          state_q, state_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic                pending_q, pending_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          lo_byte_q, lo_byte_d;
    logic [7:0]          hi_byte_q, hi_byte_d;
    logic [7:0]          cfg_en_q, cfg_en_d;
    logic [7:0]          cfg_out_q, cfg_out_d;
    logic [15:0]         mem_q [STEPS];
    logic [15:0]         mem_d [STEPS];
    logic [15:0]         cur_word;
    logic                fsm_idle;
    logic                accept_pend;
    logic                accept_trig;
    logic                accept;
    logic                unused_rsvd;

    tempo_divider #(
        .TEMPO_BITS (TEMPO_BITS)
    ) u_tempo (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .tempo   (tempo),
        .trigger (trigger)
    );

    // ------------------------------------------------------------------
    // Pattern storage. The word played this cycle comes from the current
    // flop contents, so a write to the same address lands after the read.
    // ------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        if (prog_we) begin
            mem_d[prog_addr] = prog_data;
        end
    end

    always_comb begin
        cur_word    = mem_q[idx_q];
        unused_rsvd = ^cur_word[RSVD_MSB:RSVD_LSB];   // reserved bits carry no meaning
    end

    // ------------------------------------------------------------------
    // Trigger acceptance. A parked trigger has priority when the FSM is
    // back in IDLE; any trigger arriving while one is parked is lost.
    // ------------------------------------------------------------------
    always_comb begin
        fsm_idle    = (state_q == ST_IDLE);
        accept_pend = fsm_idle && pending_q;
        accept_trig = fsm_idle && !pending_q && trigger;
        accept      = accept_pend || accept_trig;

        pending_d = pending_q;
        if (accept_pend) begin
            pending_d = 1'b0;
        end else if (trigger && !pending_q && !fsm_idle) begin
            pending_d = 1'b1;
        end

        overrun_d = overrun_q || (trigger && pending_q);

        idx_d     = idx_q;
        lo_byte_d = lo_byte_q;
        hi_byte_d = hi_byte_q;
        if (accept) begin
            lo_byte_d = lane_lo_byte(cur_word);
            hi_byte_d = lane_hi_byte(cur_word);
            if (cur_word[END_BIT] || (idx_q == IDX_BITS'(STEPS - 1))) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Write FSM. A rest word is consumed without leaving IDLE. Lane
    // outputs are decoded from the next state and registered so cfg_en
    // and cfg_out change together with the state flop.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cfg_en_d  = LANE_NONE;
        cfg_out_d = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (accept && !cur_word[REST_BIT]) begin
                    state_d = ST_WR_LO;
                end
            end
            ST_WR_LO:     state_d = ST_WR_HI;
`ifdef NOTE_SEQ_OSC_TRACK_EN
            ST_WR_HI:     state_d = ST_WR_OSC_LO;
            ST_WR_OSC_LO: state_d = ST_WR_OSC_HI;
            ST_WR_OSC_HI: state_d = ST_IDLE;
`else
            ST_WR_HI:     state_d = ST_IDLE;
`endif
            default:      state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_WR_LO: begin
                cfg_en_d  = LANE0_EN;
                cfg_out_d = lo_byte_d;
            end
            ST_WR_HI: begin
                cfg_en_d  = LANE1_EN;
                cfg_out_d = hi_byte_d;
            end
`ifdef NOTE_SEQ_OSC_TRACK_EN
            ST_WR_OSC_LO: begin
                cfg_en_d  = LANE2_EN;
                cfg_out_d = lo_byte_d;
            end
            ST_WR_OSC_HI: begin
                cfg_en_d  = LANE3_EN;
                cfg_out_d = hi_byte_d;
            end
`endif
            default: begin
                cfg_en_d  = LANE_NONE;
                cfg_out_d = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            lo_byte_q <= 8'h00;
            hi_byte_q <= 8'h00;
            cfg_en_q  <= LANE_NONE;
            cfg_out_q <= 8'h00;
            mem_q     <= '{default: REST_WORD};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            lo_byte_q <= lo_byte_d;
            hi_byte_q <= hi_byte_d;
            cfg_en_q  <= cfg_en_d;
            cfg_out_q <= cfg_out_d;
            mem_q     <= mem_d;
        end
    end

    assign cfg_en     = cfg_en_q;
    assign cfg_out    = cfg_out_q;
    assign step_idx   = idx_q;
    assign step_pulse = trigger;
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_sequencer
//  Description : Self-checking bench for note_sequencer. A behavioural model
//                keeps the pattern, a write queue and the trigger bookkeeping
//                and is advanced once per clock alongside the DUT.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_note_sequencer;

    localparam int STEPS      = 8;
    localparam int TEMPO_BITS = 16;
    localparam int IDX_BITS   = 3;
`ifdef NOTE_SEQ_OSC_TRACK_EN
    localparam int EOP_TEMPO  = 5;
`else
    localparam int EOP_TEMPO  = 3;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  run = 1'b0;
    logic [TEMPO_BITS-1:0] tempo = '0;
    logic                  prog_we = 1'b0;
    logic [IDX_BITS-1:0]   prog_addr = '0;
    logic [15:0]           prog_data = '0;
    logic [7:0]            cfg_out;
    logic [7:0]            cfg_en;
    logic [IDX_BITS-1:0]   step_idx;
    logic                  step_pulse;
    logic                  busy;
    logic                  overrun;

    int n_checks = 0;
    int n_pass   = 0;

    note_sequencer #(.STEPS(STEPS), .TEMPO_BITS(TEMPO_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .tempo      (tempo),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .cfg_out    (cfg_out),
        .cfg_en     (cfg_en),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_pat [STEPS];
    int          m_idx;
    int          m_cnt;
    bit          m_pend;
    bit          m_ovr;
    logic [7:0]  m_en;
    logic [7:0]  m_out;
    logic [15:0] m_wq [$];     // {lane enable, byte} writes still to appear

    function automatic void model_reset();
        for (int i = 0; i < STEPS; i++) m_pat[i] = 16'h8000;
        m_idx = 0; m_cnt = 0; m_pend = 0; m_ovr = 0;
        m_en = 8'h00; m_out = 8'h00;
        m_wq.delete();
    endfunction

    function automatic void model_play(input logic [15:0] w);
        logic [7:0] lo, hi;
        lo = w[7:0];
        hi = {4'h0, w[11:8]};
        if (!w[15]) begin
            m_wq.push_back({8'h01, lo});
            m_wq.push_back({8'h02, hi});
`ifdef NOTE_SEQ_OSC_TRACK_EN
            m_wq.push_back({8'h04, lo});
            m_wq.push_back({8'h08, hi});
`endif
        end
        m_idx = (w[14] || m_idx == STEPS - 1) ? 0 : m_idx + 1;
    endfunction

    function automatic void model_step();
        bit trig, idle, pend_old;
        int te;
        logic [15:0] nxt;
        trig     = run && (m_cnt == 0);
        idle     = (m_en == 8'h00);
        pend_old = m_pend;
        te       = (tempo == 0) ? 1 : int'(tempo);
        if (idle && pend_old) begin
            m_pend = 0;
            model_play(m_pat[m_idx]);
        end
        if (trig) begin
            if (pend_old)  m_ovr = 1;
            else if (idle) model_play(m_pat[m_idx]);
            else           m_pend = 1;
        end
        if (!run)            m_cnt = 0;
        else if (m_cnt == 0) m_cnt = te - 1;
        else                 m_cnt = m_cnt - 1;
        if (prog_we) m_pat[prog_addr] = prog_data;
        if (m_wq.size() > 0) begin
            nxt = m_wq.pop_front();
            m_en = nxt[15:8]; m_out = nxt[7:0];
        end else begin
            m_en = 8'h00; m_out = 8'h00;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; prog_we = 1'b0; tempo = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic program_word(input int addr, input logic [15:0] data);
        prog_we = 1'b1; prog_addr = IDX_BITS'(addr); prog_data = data;
        cycle();
        prog_we = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0;
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if ({cfg_en, cfg_out} !== 16'h0000)
            $display("FAIL reset_cfg: got en=%h out=%h want 00/00", cfg_en, cfg_out);
        else n_pass++;
        n_checks++;
        if ({step_idx, step_pulse, busy, overrun} !== 6'b0)
            $display("FAIL reset_status: got idx=%0d pulse=%b busy=%b ovr=%b want all 0", step_idx, step_pulse, busy, overrun);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int k;
        logic [15:0] exp_seq [4];
        int n_wr;
`ifdef NOTE_SEQ_OSC_TRACK_EN
        n_wr = 4;
`else
        n_wr = 2;
`endif
        exp_seq[0] = 16'h0138; exp_seq[1] = 16'h0206; exp_seq[2] = 16'h0438; exp_seq[3] = 16'h0806;
        do_reset();
        program_word(0, 16'h0638);
        tempo = 16'd4; run = 1'b1;
        #1;
        n_checks++;
        if (step_pulse !== 1'b1) $display("FAIL basic_first_pulse: got %b want 1", step_pulse);
        else n_pass++;
        for (int i = 0; i < n_wr; i++) begin
            cycle();
            n_checks++;
            if ({cfg_en, cfg_out} !== exp_seq[i])
                $display("FAIL basic_write%0d: got en=%h out=%h want en=%h out=%h", i, cfg_en, cfg_out, exp_seq[i][15:8], exp_seq[i][7:0]);
            else n_pass++;
        end
        k = n_wr;
        while (k < 16) begin
            cycle();
            k++;
            n_checks++;
            if (step_pulse !== ((k % 4) == 0))
                $display("FAIL basic_pulse_period: cycle %0d got %b want %b", k, step_pulse, (k % 4) == 0);
            else n_pass++;
            n_checks++;
            if (cfg_en !== 8'h00 || step_idx !== IDX_BITS'(m_idx))
                $display("FAIL basic_rest_steps: got en=%h idx=%0d want en=00 idx=%0d", cfg_en, step_idx, m_idx);
            else n_pass++;
        end
    endtask

    task automatic test_end_of_pattern();
        int exp_idx [5] = '{0, 1, 2, 0, 1};
        int n = 0;
        do_reset();
        program_word(0, 16'h0101);
        program_word(1, 16'h0202);
        program_word(2, 16'h4303);
        tempo = TEMPO_BITS'(EOP_TEMPO); run = 1'b1;
        #1;
        for (int c = 0; c < 40 && n < 5; c++) begin
            if (step_pulse === 1'b1) begin
                n_checks++;
                if (step_idx !== IDX_BITS'(exp_idx[n]))
                    $display("FAIL eop_idx_seq%0d: got %0d want %0d", n, step_idx, exp_idx[n]);
                else n_pass++;
                n++;
            end
            cycle();
            n_checks++;
            if ({cfg_en, cfg_out} !== {m_en, m_out})
                $display("FAIL eop_cfg: got en=%h out=%h want en=%h out=%h", cfg_en, cfg_out, m_en, m_out);
            else n_pass++;
        end
        n_checks++;
        if (n != 5) $display("FAIL eop_pulse_count: got %0d want 5", n);
        else n_pass++;
    endtask

    task automatic test_overrun();
        logic [5:0] exp_st;
        do_reset();
        program_word(0, 16'h0638);
        program_word(1, 16'h0A55);
        tempo = 16'd1; run = 1'b1;
        repeat (3) cycle();
        n_checks++;
        if (overrun !== 1'b1 || step_idx !== 3'd1)
            $display("FAIL overrun_by_cycle3: got ovr=%b idx=%0d want ovr=1 idx=1", overrun, step_idx);
        else n_pass++;
        for (int c = 0; c < 24; c++) begin
            cycle();
            exp_st = {IDX_BITS'(m_idx), m_en != 8'h00, m_ovr, run && (m_cnt == 0)};
            n_checks++;
            if ({cfg_en, cfg_out} !== {m_en, m_out})
                $display("FAIL overrun_cfg: got en=%h out=%h want en=%h out=%h", cfg_en, cfg_out, m_en, m_out);
            else n_pass++;
            n_checks++;
            if ({step_idx, busy, overrun, step_pulse} !== exp_st)
                $display("FAIL overrun_status: got %b want %b", {step_idx, busy, overrun, step_pulse}, exp_st);
            else n_pass++;
            n_checks++;
            if ($countones(cfg_en) > 1) $display("FAIL overrun_onehot: got en=%h want at most one bit", cfg_en);
            else n_pass++;
        end
    endtask

    task automatic test_tempo_zero_run_stop();
        bit found = 0;
        logic [IDX_BITS-1:0] frozen;
        do_reset();
        program_word(0, 16'h0638);
        tempo = 16'd0; run = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_checks++;
            if (step_pulse !== 1'b1 || {cfg_en, cfg_out} !== {m_en, m_out})
                $display("FAIL tempo0_behaviour: got pulse=%b en=%h out=%h want pulse=1 en=%h out=%h", step_pulse, cfg_en, cfg_out, m_en, m_out);
            else n_pass++;
        end
        for (int c = 0; c < 40 && !found; c++) begin
            cycle();
            if (cfg_en === 8'h01) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL tempo0_find_wr_lo: got no lane0 write want one within 40 cycles");
        else n_pass++;
        run = 1'b0;
        cycle();
        n_checks++;
        if ({cfg_en, cfg_out} !== 16'h0206)
            $display("FAIL runstop_wr_hi: got en=%h out=%h want en=02 out=06", cfg_en, cfg_out);
        else n_pass++;
        repeat (6) cycle();
        frozen = step_idx;
        n_checks++;
        if (step_idx !== IDX_BITS'(m_idx)) $display("FAIL runstop_idx: got %0d want %0d", step_idx, m_idx);
        else n_pass++;
        for (int c = 0; c < 8; c++) begin
            cycle();
            n_checks++;
            if (step_idx !== frozen || step_pulse !== 1'b0 || cfg_en !== 8'h00)
                $display("FAIL runstop_frozen: got idx=%0d pulse=%b en=%h want idx=%0d pulse=0 en=00", step_idx, step_pulse, cfg_en, frozen);
            else n_pass++;
        end
    endtask

    task automatic test_prog_collision();
        logic [7:0] got_lo = 8'h00;
        logic [7:0] got_hi = 8'h00;
        bit seen_lo = 0, seen_hi = 0;
        do_reset();
        program_word(0, 16'h0638);
        tempo = 16'd4; run = 1'b1;
        prog_we = 1'b1; prog_addr = '0; prog_data = 16'h0123;
        cycle();
        prog_we = 1'b0;
        n_checks++;
        if ({cfg_en, cfg_out} !== 16'h0138)
            $display("FAIL collide_old_lo: got en=%h out=%h want en=01 out=38", cfg_en, cfg_out);
        else n_pass++;
        cycle();
        n_checks++;
        if ({cfg_en, cfg_out} !== 16'h0206)
            $display("FAIL collide_old_hi: got en=%h out=%h want en=02 out=06", cfg_en, cfg_out);
        else n_pass++;
        for (int c = 0; c < 44 && !(seen_lo && seen_hi); c++) begin
            cycle();
            if (cfg_en === 8'h01 && !seen_lo) begin got_lo = cfg_out; seen_lo = 1; end
            if (cfg_en === 8'h02 && !seen_hi) begin got_hi = cfg_out; seen_hi = 1; end
        end
        n_checks++;
        if (got_lo !== 8'h23 || got_hi !== 8'h01)
            $display("FAIL collide_new_word: got lo=%h hi=%h want lo=23 hi=01", got_lo, got_hi);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit found = 0;
        do_reset();
        program_word(0, 16'h0638);
        tempo = 16'd1; run = 1'b1;
        repeat (3) cycle();
        for (int c = 0; c < 40 && !found; c++) begin
            cycle();
            if (cfg_en === 8'h01) found = 1;
        end
        n_checks++;
        if (!found || overrun !== 1'b1)
            $display("FAIL areset_setup: got found=%0d ovr=%b want found=1 ovr=1", found, overrun);
        else n_pass++;
        #2;
        rst_n = 1'b0; run = 1'b0;
        #1;
        n_checks++;
        if ({cfg_en, cfg_out} !== 16'h0000 || busy !== 1'b0)
            $display("FAIL areset_immediate: got en=%h out=%h busy=%b want 00/00/0", cfg_en, cfg_out, busy);
        else n_pass++;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({step_idx, busy, overrun} !== 5'b0)
            $display("FAIL areset_after: got idx=%0d busy=%b ovr=%b want 0/0/0", step_idx, busy, overrun);
        else n_pass++;
        tempo = 16'd2; run = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cycle();
            n_checks++;
            if (cfg_en !== 8'h00 || step_idx !== IDX_BITS'(m_idx))
                $display("FAIL areset_pattern_rest: got en=%h idx=%0d want en=00 idx=%0d", cfg_en, step_idx, m_idx);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        logic [5:0]  exp_st;
        do_reset();
        for (int a = 0; a < STEPS; a++) begin
            w = 16'($urandom);
            w[15] = ($urandom_range(0, 3) == 0);
            w[14] = ($urandom_range(0, 7) == 0);
            program_word(a, w);
        end
        tempo = TEMPO_BITS'($urandom_range(0, 6)); run = 1'b1;
        for (int c = 0; c < 500; c++) begin
            cycle();
            exp_st = {IDX_BITS'(m_idx), m_en != 8'h00, m_ovr, run && (m_cnt == 0)};
            n_checks++;
            if ({cfg_en, cfg_out} !== {m_en, m_out})
                $display("FAIL random_cfg: cycle %0d got en=%h out=%h want en=%h out=%h", c, cfg_en, cfg_out, m_en, m_out);
            else n_pass++;
            n_checks++;
            if ({step_idx, busy, overrun, step_pulse} !== exp_st)
                $display("FAIL random_status: cycle %0d got %b want %b", c, {step_idx, busy, overrun, step_pulse}, exp_st);
            else n_pass++;
            n_checks++;
            if ($countones(cfg_en) > 1) $display("FAIL random_onehot: got en=%h want at most one bit", cfg_en);
            else n_pass++;
            if ($urandom_range(0, 15) == 0) run = ~run;
            if ($urandom_range(0, 31) == 0) tempo = TEMPO_BITS'($urandom_range(0, 6));
            prog_we = ($urandom_range(0, 9) == 0);
            prog_addr = IDX_BITS'($urandom_range(0, STEPS - 1));
            w = 16'($urandom);
            w[15] = ($urandom_range(0, 3) == 0);
            prog_data = w;
        end
        prog_we = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_end_of_pattern();
        test_overrun();
        test_tempo_zero_run_stop();
        test_prog_collision();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
